// File: rtl/ram_word_writer_pkg.sv
// Shared types and defaults for the 1-bit RAM word writer.
// The optional read-back verify is enabled by defining RAM_WRITER_VERIFY_EN.
package ram_word_writer_pkg;

  localparam int WORD_W_DEF = 17;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // True for the states that walk the address window.
  function automatic logic is_active(input state_t s);
    return (s == S_WRITE) || (s == S_VERIFY);
  endfunction

endpackage

// File: rtl/ram_word_writer_if.sv
// Request handshake plus RAM pin bundle between requester, writer and the 1-bit RAM.
// ram_dataout is only consumed by the writer when RAM_WRITER_VERIFY_EN is defined.
interface ram_word_writer_if #(
  parameter int WORD_W = ram_word_writer_pkg::WORD_W_DEF,
  parameter int ADDR_W = ram_word_writer_pkg::ADDR_W_DEF
);

  logic              wr_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] word_in;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              verify_err;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_datain;
  logic              ram_store;
  logic              ram_dataout;

  modport slave (
    input  wr_valid, word_in, base_addr, ram_dataout,
    output wr_ready, busy, done, verify_err, ram_address, ram_datain, ram_store
  );

  modport master (
    output wr_valid, word_in, base_addr, ram_dataout,
    input  wr_ready, busy, done, verify_err, ram_address, ram_datain, ram_store
  );

endinterface

// File: rtl/ram_word_writer_shift.sv
// Parallel-load, MSB-out shift register feeding the RAM datain bit stream.
// With RAM_WRITER_VERIFY_EN it also keeps the loaded word so it can be replayed for read-back.
module word_shift_reg #(
  parameter int WORD_W = ram_word_writer_pkg::WORD_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
`ifdef RAM_WRITER_VERIFY_EN
  input  logic              i_reload,
  output logic              o_msb,
`endif
  output logic              o_msb_next
);

  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] w_shift_next;

`ifdef RAM_WRITER_VERIFY_EN
  logic [WORD_W-1:0] r_copy;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_copy <= '0;
    end else if (i_load) begin
      r_copy <= i_data;
    end
  end

  assign o_msb = r_shift[WORD_W-1];
`endif

  always_comb begin
    w_shift_next = r_shift;
    if (i_load) begin
      w_shift_next = i_data;
`ifdef RAM_WRITER_VERIFY_EN
    end else if (i_reload) begin
      w_shift_next = r_copy;
`endif
    end else if (i_shift) begin
      w_shift_next = {r_shift[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_shift <= '0;
    end else begin
      r_shift <= w_shift_next;
    end
  end

  // Exposes the bit that will sit on the MSB after this edge, so datain can be registered.
  assign o_msb_next = w_shift_next[WORD_W-1];

endmodule

// File: rtl/ram_word_writer.sv
// Serialises one parallel word into WORD_W single-bit RAM stores, MSB first, at base..base+WORD_W-1.
// Defining RAM_WRITER_VERIFY_EN adds a read-back pass that raises a sticky verify_err on mismatch.
module ram_word_writer
  import ram_word_writer_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               clk,
  input logic               clear,
  ram_word_writer_if.slave  bus
);

  localparam int             K_W    = $clog2(WORD_W + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(WORD_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    w_k_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_base_sel;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] w_address_next;
  logic              r_store;
  logic              r_datain;
  logic              r_busy;
  logic              r_done;
  logic              r_ready;
  logic              w_load;
  logic              w_shift;
  logic              w_msb_next;
  logic              w_active_next;

`ifdef RAM_WRITER_VERIFY_EN
  logic              w_reload;
  logic              w_msb;
  logic              r_verify_err;
  logic              w_verify_err_next;
`endif

  word_shift_reg #(
    .WORD_W (WORD_W)
  ) u_shift (
    .clk        (clk),
    .clear      (clear),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (bus.word_in),
`ifdef RAM_WRITER_VERIFY_EN
    .i_reload   (w_reload),
    .o_msb      (w_msb),
`endif
    .o_msb_next (w_msb_next)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_load       = 1'b0;
    w_shift      = 1'b0;
`ifdef RAM_WRITER_VERIFY_EN
    w_reload          = 1'b0;
    w_verify_err_next = r_verify_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.wr_valid) begin
          w_state_next = S_WRITE;
          w_k_next     = '0;
          w_load       = 1'b1;
`ifdef RAM_WRITER_VERIFY_EN
          w_verify_err_next = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        w_shift = 1'b1;
        if (r_k == K_LAST) begin
          w_k_next = '0;
`ifdef RAM_WRITER_VERIFY_EN
          w_state_next = S_VERIFY;
          w_reload     = 1'b1;
`else
          w_state_next = S_DONE;
`endif
        end else begin
          w_k_next = r_k + K_W'(1);
        end
      end
      S_VERIFY: begin
`ifdef RAM_WRITER_VERIFY_EN
        // RAM read is combinational, so the bit for address base+k is on dataout this cycle.
        w_shift = 1'b1;
        if (bus.ram_dataout != w_msb) begin
          w_verify_err_next = 1'b1;
        end
        if (r_k == K_LAST) begin
          w_state_next = S_DONE;
          w_k_next     = '0;
        end else begin
          w_k_next = r_k + K_W'(1);
        end
`else
        w_state_next = S_DONE;
`endif
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_active_next  = is_active(w_state_next);
    w_base_sel     = w_load ? bus.base_addr : r_base;
    // Plain ADDR_W-bit add: the window wraps from the top of the RAM back to 0.
    w_address_next = w_active_next ? (w_base_sel + ADDR_W'(w_k_next)) : r_address;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_k       <= '0;
      r_base    <= '0;
      r_address <= '0;
      r_store   <= 1'b0;
      r_datain  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_k       <= w_k_next;
      r_base    <= w_base_sel;
      r_address <= w_address_next;
      r_store   <= (w_state_next == S_WRITE);
      r_datain  <= (w_state_next == S_WRITE) && w_msb_next;
      r_busy    <= w_active_next;
      r_done    <= (w_state_next == S_DONE);
      r_ready   <= (w_state_next == S_IDLE);
    end
  end

`ifdef RAM_WRITER_VERIFY_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_verify_err <= 1'b0;
    end else begin
      r_verify_err <= w_verify_err_next;
    end
  end

  assign bus.verify_err = r_verify_err;
`else
  assign bus.verify_err = 1'b0;
`endif

  assign bus.wr_ready    = r_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.ram_address = r_address;
  assign bus.ram_datain  = r_datain;
  assign bus.ram_store   = r_store;

endmodule
